// File: rtl/tx_pkg.sv
// Shared transmit-path types: channel state encoding and default word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_pkg;

    // Default channel word width, shared with the single-source producer.
    localparam int TX_DW = 3;

    // Channel occupancy: IDLE means no word is on the channel, HOLD means a
    // word is being presented and waits for the consumer.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } tx_state_e;

    // Width of a requester index; at least one bit even for tiny configs.
    function automatic int idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/tx_rr_arbiter_if.sv
// Requester-side and channel-side signals of the round-robin transmit arbiter.
// Latency: n/a (wiring bundle).
// Backpressure: ready_i from the consumer; gnt_o tells each requester when its word is taken.
interface tx_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = tx_pkg::TX_DW
);
    localparam int IW = tx_pkg::idx_width(NREQ);

    logic [NREQ-1:0]    req_i;
    logic [NREQ*DW-1:0] data_i;
    logic [NREQ-1:0]    gnt_o;
    logic               valid_o;
    logic [DW-1:0]      data_o;
    logic [IW-1:0]      src_o;
    logic               ready_i;

    // Arbiter side: drives the channel and the grant strobes.
    modport master (
        input  req_i,
        input  data_i,
        input  ready_i,
        output gnt_o,
        output valid_o,
        output data_o,
        output src_o
    );

    // Environment side: requesters plus the downstream consumer.
    modport slave (
        output req_i,
        output data_i,
        output ready_i,
        input  gnt_o,
        input  valid_o,
        input  data_o,
        input  src_o
    );

endinterface

// File: rtl/tx_rr_pick.sv
// Rotate-priority picker: first set request scanning upward from last+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result with its own load condition.
module tx_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = tx_pkg::idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Walk the NREQ positions after the previous winner; the previous winner
    // itself is visited last, so it only wins again when nobody else asks.
    always_comb begin
        logic [IW-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IW'((int'(last) + off) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_rr_arbiter.sv
// Round-robin share of one valid/ready transmit channel among NREQ requesters.
// Latency: grant in the request cycle, word on the channel the next cycle; no bubble back-to-back.
// Backpressure: while ready_i is low a held word stays put and no new grant is issued.
module tx_rr_arbiter
    import tx_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = TX_DW
) (
    input  logic            clk,
    input  logic            reset,
    tx_rr_arbiter_if.master bus
);

    localparam int IW = idx_width(NREQ);

    tx_state_e     state_q, state_d;
    logic [IW-1:0] last_q,  last_d;
    logic [DW-1:0] data_q,  data_d;
    logic [IW-1:0] src_q,   src_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            load;
    logic            take;

    tx_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (bus.req_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // The channel can take a new word when empty, or when the held word
    // leaves this cycle; a grant is only meaningful outside reset.
    assign load = (state_q == IDLE) || bus.ready_i;
    assign take = reset && load && pick_any;

    assign bus.gnt_o   = take ? pick_gnt : '0;
    assign bus.valid_o = (state_q == HOLD);
    assign bus.data_o  = data_q;
    assign bus.src_o   = src_q;

    // Next-state and capture: pick wins over drain, which gives zero-bubble
    // hand-over; a drain with nothing pending empties the channel.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        src_d   = src_q;
        if (take) begin
            state_d = HOLD;
            last_d  = pick_idx;
            data_d  = bus.data_i[int'(pick_idx)*DW +: DW];
            src_d   = pick_idx;
        end else if (state_q == HOLD && bus.ready_i) begin
            state_d = IDLE;
        end
    end

    // State, pointer and channel registers; reset drops any held word and
    // parks the pointer on the top index so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Bench for tx_rr_arbiter: directed vectors, literal expectations and a per-cycle model compare.
// Latency: n/a.
// Backpressure: ready_i driven directly by the stimulus.
module tb_tx_rr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 3;

    logic clk;
    logic reset;

    tx_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    tx_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Channel described as "is a word present, which word, from whom, who
    // was served last"; the winner is the first pending requester in the
    // rotation order that starts just after the last served one.
    bit       m_init  = 1'b0;
    bit       m_valid;
    int       m_data;
    int       m_src;
    int       m_last;

    function automatic int model_pick();
        if (!reset) return -1;
        if (m_valid && !bus.ready_i) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (bus.req_i[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_gnt();
        logic [NREQ-1:0] g;
        int p;
        g = '0;
        p = model_pick();
        if (p >= 0) g[p] = 1'b1;
        return g;
    endfunction

    // Model advance at the same edge the DUT registers sample.
    always @(posedge clk) begin
        int p;
        if (!reset) begin
            m_valid = 1'b0;
            m_data  = 0;
            m_src   = 0;
            m_last  = NREQ - 1;
            m_init  = 1'b1;
        end else if (m_init) begin
            p = model_pick();
            if (p >= 0) begin
                m_valid = 1'b1;
                m_data  = int'(bus.data_i[p*DW +: DW]);
                m_src   = p;
                m_last  = p;
            end else if (m_valid && bus.ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare every cycle, mid-period, once the model has seen a reset.
    always @(negedge clk) begin
        if (m_init) begin
            chk("mdl_gnt",   32'(bus.gnt_o),   32'(model_gnt()));
            chk("mdl_valid", 32'(bus.valid_o), 32'(m_valid));
            chk("mdl_data",  32'(bus.data_o),  32'(m_data));
            chk("mdl_src",   32'(bus.src_o),   32'(m_src));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] g;
        reset       = 1'b0;
        bus.req_i   = '0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;

        // Reset then idle
        step();
        step();
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_data",  32'(bus.data_o),  32'd0);
        chk("rst_src",   32'(bus.src_o),   32'd0);
        chk("rst_gnt",   32'(bus.gnt_o),   32'd0);
        reset = 1'b1;
        step();
        chk("idle_valid", 32'(bus.valid_o), 32'd0);
        chk("idle_gnt",   32'(bus.gnt_o),   32'd0);

        // Single request from index 2 under backpressure
        bus.data_i = {3'b000, 3'b101, 3'b000, 3'b000};
        bus.req_i  = 4'b0100;
        #1;
        chk("single_gnt", 32'(bus.gnt_o), 32'b0100);
        step();
        bus.req_i = '0;
        #1;
        chk("single_valid", 32'(bus.valid_o), 32'd1);
        chk("single_data",  32'(bus.data_o),  32'b101);
        chk("single_src",   32'(bus.src_o),   32'd2);
        chk("single_gnt0",  32'(bus.gnt_o),   32'd0);
        repeat (5) begin
            step();
            chk("hold_valid", 32'(bus.valid_o), 32'd1);
            chk("hold_data",  32'(bus.data_o),  32'b101);
            chk("hold_src",   32'(bus.src_o),   32'd2);
        end
        bus.ready_i = 1'b1;
        #1;
        chk("drain_gnt", 32'(bus.gnt_o), 32'd0);
        step();
        chk("drain_valid", 32'(bus.valid_o), 32'd0);
        chk("drain_data",  32'(bus.data_o),  32'b101);
        bus.ready_i = 1'b0;

        // Restore index-0 priority
        reset = 1'b0;
        step();
        reset = 1'b1;

        // Round-robin rotation, full throughput
        bus.data_i  = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.req_i   = 4'b1111;
        bus.ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            g = '0;
            g[k % NREQ] = 1'b1;
            chk("rot_gnt", 32'(bus.gnt_o), 32'(g));
            step();
            chk("rot_valid", 32'(bus.valid_o), 32'd1);
            chk("rot_src",   32'(bus.src_o),   32'(k % NREQ));
            chk("rot_data",  32'(bus.data_o),  32'(k % NREQ));
        end
        bus.req_i = '0;
        step();
        chk("rot_end_valid", 32'(bus.valid_o), 32'd0);
        bus.ready_i = 1'b0;

        // Backpressure with two pending requesters (last served = 1)
        bus.req_i = 4'b0011;
        #1;
        chk("bp_gnt_first", 32'(bus.gnt_o), 32'b0001);
        step();
        chk("bp_src0", 32'(bus.src_o), 32'd0);
        repeat (4) begin
            #1;
            chk("bp_gnt_held", 32'(bus.gnt_o), 32'd0);
            step();
            chk("bp_src_held", 32'(bus.src_o),   32'd0);
            chk("bp_vld_held", 32'(bus.valid_o), 32'd1);
        end
        bus.ready_i = 1'b1;
        #1;
        chk("bp_gnt_release", 32'(bus.gnt_o), 32'b0010);
        step();
        chk("bp_src1",   32'(bus.src_o),   32'd1);
        chk("bp_valid1", 32'(bus.valid_o), 32'd1);
        bus.req_i = '0;
        step();
        chk("bp_end_valid", 32'(bus.valid_o), 32'd0);

        // Wrap-around: lone requester 3 wins twice, then 1, then 0
        bus.req_i = 4'b1000;
        #1;
        chk("wrap_gnt3a", 32'(bus.gnt_o), 32'b1000);
        step();
        chk("wrap_src3a", 32'(bus.src_o), 32'd3);
        #1;
        chk("wrap_gnt3b", 32'(bus.gnt_o), 32'b1000);
        step();
        chk("wrap_src3b", 32'(bus.src_o), 32'd3);
        bus.req_i = 4'b0010;
        #1;
        chk("wrap_gnt1", 32'(bus.gnt_o), 32'b0010);
        step();
        bus.req_i = 4'b0001;
        #1;
        chk("wrap_gnt0", 32'(bus.gnt_o), 32'b0001);
        step();
        chk("wrap_src0", 32'(bus.src_o), 32'd0);
        bus.req_i = '0;
        step();
        chk("wrap_end_valid", 32'(bus.valid_o), 32'd0);
        bus.ready_i = 1'b0;

        // Reset while a word is held
        bus.data_i = {3'b000, 3'b110, 3'b000, 3'b011};
        bus.req_i  = 4'b0100;
        step();
        chk("mid_valid", 32'(bus.valid_o), 32'd1);
        chk("mid_data",  32'(bus.data_o),  32'b110);
        bus.req_i = 4'b0101;
        reset     = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt_o), 32'd0);
        step();
        chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        chk("mid_rst_data",  32'(bus.data_o),  32'd0);
        reset = 1'b1;
        #1;
        chk("mid_post_gnt", 32'(bus.gnt_o), 32'b0001);
        step();
        chk("mid_post_src",  32'(bus.src_o),  32'd0);
        chk("mid_post_data", 32'(bus.data_o), 32'b011);
        bus.req_i   = '0;
        bus.ready_i = 1'b1;
        step();
        chk("mid_end_valid", 32'(bus.valid_o), 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
